// File: rtl/symbol_fetch.sv
// Symbol fetch sequencer: scans the command-buffer slots flagged at frame start and
// hands each stored symbol to the drawing engine. Optional macro: SYMFETCH_FRAME_ABORT_EN.
module symbol_fetch #(
    parameter int BUFFER_PKT_BITS = 32,
    parameter int NUM_SYM_SUPPTD  = 8,
    parameter int IDX_BITS        = 3
) (
    input  logic                       i_clk,
    input  logic                       n_btn_rst,
    input  logic                       i_frame_start,
    input  logic [NUM_SYM_SUPPTD-1:0]  i_valid_idx,
    output logic                       o_re,
    output logic [IDX_BITS-1:0]        o_raddr,
    input  logic [BUFFER_PKT_BITS-1:0] i_rdata,
    output logic                       o_sym_valid,
    input  logic                       i_sym_ready,
    output logic [BUFFER_PKT_BITS-1:0] o_sym_data,
    output logic [IDX_BITS-1:0]        o_sym_id,
    output logic                       o_busy,
    output logic                       o_frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SYM_SUPPTD - 1);
    localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

    state_t                       state_r, state_nxt_s;
    logic [IDX_BITS-1:0]          idx_r, idx_nxt_s;
    logic [NUM_SYM_SUPPTD-1:0]    mask_r, mask_nxt_s;
    logic [BUFFER_PKT_BITS-1:0]   sym_data_r, sym_data_nxt_s;
    logic [IDX_BITS-1:0]          sym_id_r, sym_id_nxt_s;
    logic                         abort_s;
    logic                         in_scan_s;

`ifdef SYMFETCH_FRAME_ABORT_EN
    assign abort_s = i_frame_start;
`else
    assign abort_s = 1'b0;
`endif

    assign in_scan_s = (state_r == ST_SCAN) || (state_r == ST_WAIT) || (state_r == ST_PRESENT);

    // Next-state, slot index, mask snapshot and symbol capture decode.
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        mask_nxt_s     = mask_r;
        sym_data_nxt_s = sym_data_r;
        sym_id_nxt_s   = sym_id_r;
        if (abort_s && in_scan_s) begin
            // Restart drops the current scan without a completion pulse.
            mask_nxt_s  = i_valid_idx;
            idx_nxt_s   = '0;
            state_nxt_s = ST_SCAN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        mask_nxt_s  = i_valid_idx;
                        idx_nxt_s   = '0;
                        state_nxt_s = ST_SCAN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (mask_r[idx_r]) begin
                        state_nxt_s = ST_WAIT;
                    end else if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                        state_nxt_s = ST_SCAN;
                    end
                end
                ST_WAIT: begin
                    sym_data_nxt_s = i_rdata;
                    sym_id_nxt_s   = idx_r;
                    state_nxt_s    = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (!i_sym_ready) begin
                        state_nxt_s = ST_PRESENT;
                    end else if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                        state_nxt_s = ST_SCAN;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    idx_nxt_s   = '0;
                    mask_nxt_s  = '0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!n_btn_rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            mask_r     <= '0;
            sym_data_r <= '0;
            sym_id_r   <= '0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            mask_r     <= mask_nxt_s;
            sym_data_r <= sym_data_nxt_s;
            sym_id_r   <= sym_id_nxt_s;
        end
    end

    // Read enable is issued in the same cycle the occupied slot is found.
    assign o_re         = (state_r == ST_SCAN) && mask_r[idx_r];
    assign o_raddr      = idx_r;
    assign o_sym_valid  = (state_r == ST_PRESENT);
    assign o_sym_data   = sym_data_r;
    assign o_sym_id     = sym_id_r;
    assign o_busy       = (state_r != ST_IDLE);
    assign o_frame_done = (state_r == ST_DONE);

endmodule

// File: tb/tb_symbol_fetch.sv
// Directed testbench for symbol_fetch with a small command-buffer model.
module tb_symbol_fetch;

    logic        i_clk = 1'b0;
    logic        n_btn_rst = 1'b0;
    logic        i_frame_start = 1'b0;
    logic [7:0]  i_valid_idx = 8'h00;
    logic        o_re;
    logic [2:0]  o_raddr;
    logic [31:0] i_rdata = 32'h0;
    logic        o_sym_valid;
    logic        i_sym_ready = 1'b1;
    logic [31:0] o_sym_data;
    logic [2:0]  o_sym_id;
    logic        o_busy;
    logic        o_frame_done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [8];

    int          got_n;
    logic [2:0]  got_id [16];
    logic [31:0] got_data [16];
    int          done_cnt, done_cyc, re_cnt, first_re, valid_cnt, first_valid;
    logic        idle_after;

    symbol_fetch #(.BUFFER_PKT_BITS(32), .NUM_SYM_SUPPTD(8), .IDX_BITS(3)) dut (
        .i_clk(i_clk), .n_btn_rst(n_btn_rst), .i_frame_start(i_frame_start),
        .i_valid_idx(i_valid_idx), .o_re(o_re), .o_raddr(o_raddr), .i_rdata(i_rdata),
        .o_sym_valid(o_sym_valid), .i_sym_ready(i_sym_ready), .o_sym_data(o_sym_data),
        .o_sym_id(o_sym_id), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    // Command buffer: data valid the cycle after o_re, garbage otherwise.
    always @(posedge i_clk) begin
        if (o_re) i_rdata <= mem[o_raddr];
        else      i_rdata <= 32'hDEAD_BEEF;
    end

    task automatic tick;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Pulse frame start in cycle 0; returns at the sample point of cycle 1.
    task automatic start_frame(input logic [7:0] m);
        i_valid_idx   = m;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    // Record activity cycle by cycle until frame done (plus one cycle) or budget expires.
    task automatic collect(input int max_cyc, input int chg_cyc, input logic [7:0] chg_val);
        got_n = 0; done_cnt = 0; done_cyc = -1; re_cnt = 0; first_re = -1;
        valid_cnt = 0; first_valid = -1; idle_after = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (o_re) begin
                re_cnt++;
                if (first_re < 0) first_re = c;
            end
            if (o_sym_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = c;
                if (i_sym_ready && got_n < 16) begin
                    got_id[got_n]   = o_sym_id;
                    got_data[got_n] = o_sym_data;
                    got_n++;
                end
            end
            if (o_frame_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == chg_cyc) i_valid_idx = chg_val;
            tick();
            if (done_cyc >= 0) begin
                idle_after = !o_busy && !o_frame_done;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_btn_rst = 1'b0;
        tick(); tick();
        vectors++;
        if ({o_busy, o_re, o_sym_valid, o_frame_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got %b expected 0000", {o_busy, o_re, o_sym_valid, o_frame_done});
        end
        vectors++;
        if (o_sym_data !== 32'h0 || o_sym_id !== 3'd0 || o_raddr !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_regs got data=%h id=%0d raddr=%0d expected 0", o_sym_data, o_sym_id, o_raddr);
        end
        n_btn_rst = 1'b1;
        tick();
    endtask

    task automatic test_two_slots;
        i_sym_ready = 1'b1;
        start_frame(8'b0000_0101);
        collect(40, 0, 8'h00);
        vectors++;
        if (got_n !== 2 || got_id[0] !== 3'd0 || got_id[1] !== 3'd2) begin
            miscompares++;
            $display("FAIL two_ids got n=%0d ids=%0d,%0d expected 2 ids 0,2", got_n, got_id[0], got_id[1]);
        end
        vectors++;
        if (got_data[0] !== mem[0] || got_data[1] !== mem[2]) begin
            miscompares++;
            $display("FAIL two_data got %h,%h expected %h,%h", got_data[0], got_data[1], mem[0], mem[2]);
        end
        vectors++;
        if (first_re !== 1 || first_valid !== 3) begin
            miscompares++;
            $display("FAIL latency got re@%0d valid@%0d expected re@1 valid@3", first_re, first_valid);
        end
        vectors++;
        if (done_cnt !== 1 || done_cyc !== 13 || idle_after !== 1'b1) begin
            miscompares++;
            $display("FAIL two_done got cnt=%0d cyc=%0d idle=%b expected 1,13,1", done_cnt, done_cyc, idle_after);
        end
    endtask

    task automatic test_empty_mask;
        start_frame(8'h00);
        collect(20, 0, 8'h00);
        vectors++;
        if (re_cnt !== 0 || valid_cnt !== 0) begin
            miscompares++;
            $display("FAIL empty_activity got re=%0d valid=%0d expected 0,0", re_cnt, valid_cnt);
        end
        vectors++;
        if (done_cyc !== 9 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL empty_done got cyc=%0d cnt=%0d expected 9,1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_done_ignore;
        start_frame(8'h00);
        for (int c = 1; c < 9; c++) tick();
        vectors++;
        if (o_frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_pulse got %b expected 1", o_frame_done);
        end
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        vectors++;
        if (o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_ignore got busy=%b done=%b expected 0,0", o_busy, o_frame_done);
        end
        tick();
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_ignore_idle got busy=%b expected 0", o_busy);
        end
    endtask

    task automatic test_stall_last;
        int wcyc;
        i_sym_ready = 1'b0;
        start_frame(8'h80);
        wcyc = 1;
        while (!o_sym_valid && wcyc < 20) begin
            tick();
            wcyc++;
        end
        vectors++;
        if (wcyc !== 10) begin
            miscompares++;
            $display("FAIL stall_arrival got cycle %0d expected 10", wcyc);
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (o_sym_valid !== 1'b1 || o_sym_id !== 3'd7 || o_sym_data !== mem[7]) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got v=%b id=%0d data=%h expected 1,7,%h",
                         k, o_sym_valid, o_sym_id, o_sym_data, mem[7]);
            end
            tick();
        end
        i_sym_ready = 1'b1;
        tick();
        vectors++;
        if (o_frame_done !== 1'b1 || o_sym_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done got done=%b v=%b expected 1,0", o_frame_done, o_sym_valid);
        end
        tick();
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle got busy=%b expected 0", o_busy);
        end
    endtask

    task automatic test_snapshot;
        int bad;
        i_sym_ready = 1'b1;
        start_frame(8'hFF);
        collect(60, 5, 8'h00);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (got_id[i] !== 3'(i) || got_data[i] !== mem[i]) bad++;
        end
        vectors++;
        if (got_n !== 8 || bad !== 0) begin
            miscompares++;
            $display("FAIL snapshot_order got n=%0d bad=%0d expected 8,0", got_n, bad);
        end
        vectors++;
        if (done_cyc !== 25 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL snapshot_done got cyc=%0d cnt=%0d expected 25,1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_reset_in_present;
        int seen_done;
        i_sym_ready = 1'b0;
        start_frame(8'h01);
        tick(); tick();
        vectors++;
        if (o_sym_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_present got v=%b expected 1", o_sym_valid);
        end
        n_btn_rst = 1'b0;
        tick();
        vectors++;
        if ({o_busy, o_sym_valid, o_frame_done, o_re} !== 4'b0000 || o_sym_id !== 3'd0 || o_sym_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_present got flags=%b id=%0d data=%h expected 0000,0,0",
                     {o_busy, o_sym_valid, o_frame_done, o_re}, o_sym_id, o_sym_data);
        end
        n_btn_rst = 1'b1;
        i_sym_ready = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (o_frame_done || o_busy) seen_done++;
            tick();
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL rst_no_done got %0d active cycles expected 0", seen_done);
        end
    endtask

    task automatic test_restart_in_present;
        int wcyc;
        int exp_n;
        logic [2:0] exp_first;
        logic [2:0] exp_raddr;
`ifdef SYMFETCH_FRAME_ABORT_EN
        exp_n = 8; exp_first = 3'd0; exp_raddr = 3'd0;
`else
        exp_n = 4; exp_first = 3'd4; exp_raddr = 3'd4;
`endif
        i_sym_ready = 1'b1;
        start_frame(8'hFF);
        wcyc = 1;
        while (!(o_sym_valid && o_sym_id == 3'd3) && wcyc < 40) begin
            tick();
            wcyc++;
        end
        vectors++;
        if (wcyc !== 12) begin
            miscompares++;
            $display("FAIL restart_reach_id3 got cycle %0d expected 12", wcyc);
        end
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        vectors++;
        if (o_re !== 1'b1 || o_raddr !== exp_raddr) begin
            miscompares++;
            $display("FAIL restart_next got re=%b raddr=%0d expected 1,%0d", o_re, o_raddr, exp_raddr);
        end
        collect(60, 0, 8'h00);
        vectors++;
        if (got_n !== exp_n || got_id[0] !== exp_first || got_id[got_n-1] !== 3'd7 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL restart_rest got n=%0d first=%0d last=%0d done=%0d expected %0d,%0d,7,1",
                     got_n, got_id[0], got_id[got_n-1], done_cnt, exp_n, exp_first);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0111;
        @(negedge i_clk);
        test_reset();
        test_two_slots();
        test_empty_mask();
        test_done_ignore();
        test_stall_last();
        test_snapshot();
        test_reset_in_present();
        test_restart_in_present();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
